// File: rtl/ervp_axi_mem_responder_pkg.sv
// Shared AXI4 field widths, response codes and responder FSM state type
// for the ervp_axi_mem_responder slice.
package ervp_axi_mem_responder_pkg;

  localparam int BW_AXI_LEN   = 8;
  localparam int BW_AXI_SIZE  = 3;
  localparam int BW_AXI_BURST = 2;
  localparam int BW_AXI_RESP  = 2;

  localparam logic [BW_AXI_RESP-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [BW_AXI_RESP-1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_WR    = 2'd2,
    ST_WRESP = 2'd3
  } state_t;

endpackage

// File: rtl/ervp_axi_mem_responder_ram.sv
// Word RAM behind the AXI responder: one synchronous read port, one write
// port with per-byte enables. Only the read data register is reset.
module ervp_axi_mem_responder_ram #(
  parameter int BW_DATA    = 64,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    re,
  input  logic [DEPTH_LOG2-1:0]   ra,
  output logic [BW_DATA-1:0]      rd,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   wa,
  input  logic [BW_DATA-1:0]      wd,
  input  logic [BW_DATA/8-1:0]    wstrb
);

  localparam int NBYTE = BW_DATA / 8;

  logic [BW_DATA-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NBYTE; i++) begin
        if (wstrb[i]) mem[wa][i*8 +: 8] <= wd[i*8 +: 8];
      end
    end
  end

  // rd only changes when re is pulsed, so it doubles as the held r-channel data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rd <= '0;
    else if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/ervp_axi_mem_responder.sv
// AXI4 slave memory model serving INCR bursts one transaction at a time.
// Optional `AXI_MEM_RESPONDER_READ_STALL_EN inserts a bubble after each non-last read beat.
module ervp_axi_mem_responder
  import ervp_axi_mem_responder_pkg::*;
#(
  parameter int BW_ADDR    = 32,
  parameter int BW_DATA    = 64,
  parameter int BW_TID     = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BW_TID-1:0]         data_rx4aw_id,
  input  logic [BW_ADDR-1:0]        data_rx4aw_addr,
  input  logic [BW_AXI_LEN-1:0]     data_rx4aw_len,
  input  logic [BW_AXI_SIZE-1:0]    data_rx4aw_size,
  input  logic [BW_AXI_BURST-1:0]   data_rx4aw_burst,
  input  logic                      data_rx4aw_valid,
  output logic                      data_rx4aw_ready,
  input  logic [BW_DATA-1:0]        data_rx4w_data,
  input  logic [BW_DATA/8-1:0]      data_rx4w_strb,
  input  logic                      data_rx4w_last,
  input  logic                      data_rx4w_valid,
  output logic                      data_rx4w_ready,
  output logic [BW_TID-1:0]         data_rx4b_id,
  output logic [BW_AXI_RESP-1:0]    data_rx4b_resp,
  output logic                      data_rx4b_valid,
  input  logic                      data_rx4b_ready,
  input  logic [BW_TID-1:0]         data_rx4ar_id,
  input  logic [BW_ADDR-1:0]        data_rx4ar_addr,
  input  logic [BW_AXI_LEN-1:0]     data_rx4ar_len,
  input  logic [BW_AXI_SIZE-1:0]    data_rx4ar_size,
  input  logic [BW_AXI_BURST-1:0]   data_rx4ar_burst,
  input  logic                      data_rx4ar_valid,
  output logic                      data_rx4ar_ready,
  output logic [BW_TID-1:0]         data_rx4r_id,
  output logic [BW_DATA-1:0]        data_rx4r_data,
  output logic [BW_AXI_RESP-1:0]    data_rx4r_resp,
  output logic                      data_rx4r_last,
  output logic                      data_rx4r_valid,
  input  logic                      data_rx4r_ready,
  output state_t                    debug_state
);

  localparam int BYTE_LOG2 = $clog2(BW_DATA / 8);
  localparam int WORD_MSB  = DEPTH_LOG2 + BYTE_LOG2 - 1;
  localparam logic [BW_AXI_SIZE-1:0] FULL_SIZE = BW_AXI_SIZE'(BYTE_LOG2);

  // Handshakes: a beat transfers on a rising edge where valid && ready; a
  // source never drops valid or changes payload until its beat transfers.
  state_t                  state;
  logic                    ready_en;
  logic                    prio_rd;
  logic [DEPTH_LOG2-1:0]   rd_word;
  logic [BW_AXI_LEN-1:0]   r_cnt;
  logic [BW_AXI_LEN-1:0]   r_len;
  logic [DEPTH_LOG2-1:0]   w_word;
  logic [BW_AXI_LEN-1:0]   w_cnt;
  logic [BW_AXI_LEN-1:0]   w_len;
  logic                    w_err;
`ifdef AXI_MEM_RESPONDER_READ_STALL_EN
  logic                    r_bubble;
`endif

  logic                    ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic                    w_on_len, w_final, w_mismatch;
  logic [DEPTH_LOG2-1:0]   ar_word, aw_word;
  logic                    ram_re;
  logic [DEPTH_LOG2-1:0]   ram_ra;
  logic                    unused_bits;

  assign ar_word = data_rx4ar_addr[WORD_MSB:BYTE_LOG2];
  assign aw_word = data_rx4aw_addr[WORD_MSB:BYTE_LOG2];
  assign unused_bits = ^{data_rx4aw_burst, data_rx4ar_burst,
                         data_rx4aw_addr[BYTE_LOG2-1:0], data_rx4ar_addr[BYTE_LOG2-1:0],
                         data_rx4aw_addr[BW_ADDR-1:WORD_MSB+1], data_rx4ar_addr[BW_ADDR-1:WORD_MSB+1]};

  // ready_en is high only in IDLE; on a collision prio_rd picks the winner.
  assign data_rx4ar_ready = ready_en & (~data_rx4aw_valid | prio_rd);
  assign data_rx4aw_ready = ready_en & (~data_rx4ar_valid | ~prio_rd);

  assign ar_hs = data_rx4ar_valid & data_rx4ar_ready;
  assign aw_hs = data_rx4aw_valid & data_rx4aw_ready;
  assign w_hs  = data_rx4w_valid  & data_rx4w_ready;
  assign r_hs  = data_rx4r_valid  & data_rx4r_ready;
  assign b_hs  = data_rx4b_valid  & data_rx4b_ready;

  assign w_on_len   = (w_cnt == w_len);
  assign w_final    = w_on_len | data_rx4w_last;
  assign w_mismatch = data_rx4w_last ^ w_on_len;

  // Fetch the first word on ar handshake and each following word on r handshake.
  assign ram_re = ar_hs | (r_hs & ~data_rx4r_last);
  assign ram_ra = ar_hs ? ar_word : rd_word;

  assign debug_state = state;

  ervp_axi_mem_responder_ram #(
    .BW_DATA    (BW_DATA),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .re    (ram_re),
    .ra    (ram_ra),
    .rd    (data_rx4r_data),
    .we    (w_hs),
    .wa    (w_word),
    .wd    (data_rx4w_data),
    .wstrb (data_rx4w_strb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      ready_en        <= 1'b0;
      prio_rd         <= 1'b1;
      rd_word         <= '0;
      r_cnt           <= '0;
      r_len           <= '0;
      data_rx4r_valid <= 1'b0;
      data_rx4r_last  <= 1'b0;
      data_rx4r_id    <= '0;
      data_rx4r_resp  <= AXI_RESP_OKAY;
      w_word          <= '0;
      w_cnt           <= '0;
      w_len           <= '0;
      w_err           <= 1'b0;
      data_rx4w_ready <= 1'b0;
      data_rx4b_valid <= 1'b0;
      data_rx4b_id    <= '0;
      data_rx4b_resp  <= AXI_RESP_OKAY;
`ifdef AXI_MEM_RESPONDER_READ_STALL_EN
      r_bubble        <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          ready_en <= 1'b1;
          if ((ar_hs || aw_hs) && data_rx4ar_valid && data_rx4aw_valid) prio_rd <= ~prio_rd;
          if (ar_hs) begin
            state           <= ST_RD;
            ready_en        <= 1'b0;
            data_rx4r_valid <= 1'b1;
            data_rx4r_last  <= (data_rx4ar_len == '0);
            data_rx4r_id    <= data_rx4ar_id;
            data_rx4r_resp  <= (data_rx4ar_size != FULL_SIZE) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            rd_word         <= ar_word + DEPTH_LOG2'(1);
            r_cnt           <= '0;
            r_len           <= data_rx4ar_len;
          end else if (aw_hs) begin
            state           <= ST_WR;
            ready_en        <= 1'b0;
            data_rx4w_ready <= 1'b1;
            data_rx4b_id    <= data_rx4aw_id;
            w_word          <= aw_word;
            w_cnt           <= '0;
            w_len           <= data_rx4aw_len;
            w_err           <= (data_rx4aw_size != FULL_SIZE);
          end
        end
        ST_RD: begin
          if (r_hs) begin
            if (data_rx4r_last) begin
              data_rx4r_valid <= 1'b0;
              data_rx4r_last  <= 1'b0;
              state           <= ST_IDLE;
              ready_en        <= 1'b1;
            end else begin
              rd_word        <= rd_word + DEPTH_LOG2'(1);
              r_cnt          <= r_cnt + BW_AXI_LEN'(1);
              data_rx4r_last <= ((r_cnt + BW_AXI_LEN'(1)) == r_len);
`ifdef AXI_MEM_RESPONDER_READ_STALL_EN
              data_rx4r_valid <= 1'b0;
              r_bubble        <= 1'b1;
`endif
            end
          end
`ifdef AXI_MEM_RESPONDER_READ_STALL_EN
          else if (r_bubble) begin
            data_rx4r_valid <= 1'b1;
            r_bubble        <= 1'b0;
          end
`endif
        end
        ST_WR: begin
          if (w_hs) begin
            w_word <= w_word + DEPTH_LOG2'(1);
            w_cnt  <= w_cnt + BW_AXI_LEN'(1);
            // Either an early wlast or a missing wlast on beat len ends the burst with SLVERR.
            if (w_final) begin
              data_rx4w_ready <= 1'b0;
              data_rx4b_valid <= 1'b1;
              data_rx4b_resp  <= (w_err || w_mismatch) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              state           <= ST_WRESP;
            end
          end
        end
        ST_WRESP: begin
          if (b_hs) begin
            data_rx4b_valid <= 1'b0;
            state           <= ST_IDLE;
            ready_en        <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ervp_axi_mem_responder.sv
// Directed plus randomized bench for ervp_axi_mem_responder, checked against
// a word-array memory model; tolerant of the read-stall build option.
module tb_ervp_axi_mem_responder;
  import ervp_axi_mem_responder_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [63:0] wdata, rdata;
  state_t      debug_state;

  int          n_checks = 0;
  int          n_err = 0;
  logic [63:0] model_mem [DEPTH];
  logic [63:0] wb_data [256];
  logic [7:0]  wb_strb [256];
  bit          gaps;
  logic        aw_rdy_at_ar, ar_rdy_at_aw;

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  ervp_axi_mem_responder dut (
    .clk(clk), .rst(rst),
    .data_rx4aw_id(awid), .data_rx4aw_addr(awaddr), .data_rx4aw_len(awlen),
    .data_rx4aw_size(awsize), .data_rx4aw_burst(awburst), .data_rx4aw_valid(awvalid),
    .data_rx4aw_ready(awready),
    .data_rx4w_data(wdata), .data_rx4w_strb(wstrb), .data_rx4w_last(wlast),
    .data_rx4w_valid(wvalid), .data_rx4w_ready(wready),
    .data_rx4b_id(bid), .data_rx4b_resp(bresp), .data_rx4b_valid(bvalid), .data_rx4b_ready(bready),
    .data_rx4ar_id(arid), .data_rx4ar_addr(araddr), .data_rx4ar_len(arlen),
    .data_rx4ar_size(arsize), .data_rx4ar_burst(arburst), .data_rx4ar_valid(arvalid),
    .data_rx4ar_ready(arready),
    .data_rx4r_id(rid), .data_rx4r_data(rdata), .data_rx4r_resp(rresp), .data_rx4r_last(rlast),
    .data_rx4r_valid(rvalid), .data_rx4r_ready(rready),
    .debug_state(debug_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    n_checks++;
    n_err++;
    $error("FAIL %s timeout waiting for handshake", tag);
  endtask

  function automatic int word_of(input int a);
    return (a >> 3) & (DEPTH - 1);
  endfunction

  task automatic send_ar(input logic [3:0] id, input int addr, input int len, input logic [2:0] size);
    int cyc = 0;
    arid = id; araddr = 32'(addr); arlen = 8'(len); arsize = size; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && cyc < 200) begin @(negedge clk); cyc++; end
    aw_rdy_at_ar = awready;
    if (!arready) tmo("arready");
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid_cycle_after_ar", rvalid, 1);
  endtask

  task automatic send_aw(input logic [3:0] id, input int addr, input int len, input logic [2:0] size);
    int cyc = 0;
    awid = id; awaddr = 32'(addr); awlen = 8'(len); awsize = size; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && cyc < 200) begin @(negedge clk); cyc++; end
    ar_rdy_at_aw = arready;
    if (!awready) tmo("awready");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  // mode 0: rready always high, 1: toggles starting low, 2: random
  task automatic read_data(input logic [3:0] id, input int addr, input int len, input bit size_err,
                           input int mode);
    int b = 0;
    int cyc = 0;
    bit tog = 1'b0;
    int w0 = word_of(addr);
    while (b <= len) begin
      case (mode)
        0:       rready = 1'b1;
        1:       begin rready = tog; tog = ~tog; end
        default: rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (rvalid) begin
        chk($sformatf("rdata beat %0d", b), rdata, model_mem[(w0 + b) % DEPTH]);
        chk($sformatf("rlast beat %0d", b), rlast, (b == len));
        chk("rid", rid, id);
        chk("rresp", rresp, size_err ? 2'b10 : 2'b00);
        if (rready) b++;
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc > 3000) begin tmo("rbeat"); break; end
    end
    rready = 1'b0;
  endtask

  task automatic write_data(input logic [3:0] id, input int addr, input int len, input bit size_err,
                            input int last_at);
    int cyc;
    int nb = ((last_at < len) ? last_at : len) + 1;
    bit err = size_err || (last_at != len);
    int w0 = word_of(addr);
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
      wdata = wb_data[b]; wstrb = wb_strb[b]; wlast = (b == last_at); wvalid = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!wready && cyc < 100) begin @(negedge clk); cyc++; end
      if (!wready) tmo("wready");
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++)
        if (wb_strb[b][i]) model_mem[(w0 + b) % DEPTH][i*8 +: 8] = wb_data[b][i*8 +: 8];
      wvalid = 1'b0; wlast = 1'b0;
    end
    chk("bvalid_cycle_after_last_w", bvalid, 1);
    chk("wready_low_in_wresp", wready, 0);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    chk("bvalid_held", bvalid, 1);
    bready = 1'b1;
    @(negedge clk);
    chk("bid", bid, id);
    chk("bresp", bresp, err ? 2'b10 : 2'b00);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] id, input int addr, input int len,
                             input logic [2:0] size, input int last_at);
    send_aw(id, addr, len, size);
    write_data(id, addr, len, size != 3'd3, last_at);
  endtask

  task automatic read_burst(input logic [3:0] id, input int addr, input int len,
                            input logic [2:0] size, input int mode);
    send_ar(id, addr, len, size);
    read_data(id, addr, len, size != 3'd3, mode);
  endtask

  int          nb, cyc, len, addr, la;
  logic [2:0]  sz;

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    gaps = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ids_resps_last", {rid, bid, rresp, bresp, rlast}, 0);
    chk("rst_state", debug_state, ST_IDLE);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_arready", arready, 1);
    chk("idle_awready", awready, 1);

    // Fill the whole RAM with full 256-beat bursts so every later read is known.
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 256; b++) begin wb_data[b] = {$urandom, $urandom}; wb_strb[b] = 8'hFF; end
      write_burst(4'(k), k * 2048, 255, 3'd3, 255);
    end
    read_burst(4'hA, 896 * 8, 255, 3'd3, 0);

    wb_data[0] = 64'h1122334455667788; wb_strb[0] = 8'hFF;
    write_burst(4'd3, 'h10, 0, 3'd3, 0);
    read_burst(4'd3, 'h10, 0, 3'd3, 0);

    for (int b = 0; b < 16; b++) begin wb_data[b] = 64'(b); wb_strb[b] = 8'hFF; end
    write_burst(4'd1, 'h100, 15, 3'd3, 15);
    read_burst(4'd2, 'h100, 15, 3'd3, 1);

    wb_data[0] = '1; wb_strb[0] = 8'hFF;
    write_burst(4'd4, 'h200, 0, 3'd3, 0);
    wb_data[0] = 64'hAAAAAAAA_BBBBBBBB; wb_strb[0] = 8'h0F;
    write_burst(4'd4, 'h200, 0, 3'd3, 0);
    read_burst(4'd4, 'h200, 0, 3'd3, 0);
    chk("strb_merge_model", model_mem[word_of('h200)], 64'hFFFFFFFF_BBBBBBBB);

    for (int b = 0; b < 4; b++) begin wb_data[b] = {$urandom, $urandom}; wb_strb[b] = 8'hFF; end
    write_burst(4'd5, 'h300, 3, 3'd3, 2);
    wb_data[0] = {$urandom, $urandom};
    write_burst(4'd6, 'h340, 0, 3'd3, 0);
    read_burst(4'd5, 'h300, 3, 3'd3, 0);
    write_burst(4'd7, 'h400, 1, 3'd3, 2);
    write_burst(4'd8, 'h500, 1, 3'd2, 1);
    read_burst(4'd8, 'h500, 1, 3'd2, 0);
    for (int b = 0; b < 4; b++) wb_data[b] = {$urandom, $urandom};
    write_burst(4'd9, 1022 * 8 + 5, 3, 3'd3, 3);
    read_burst(4'd9, 1022 * 8, 3, 3'd3, 2);

    // Address collisions: read wins first, then priority flips to write.
    wb_data[0] = {$urandom, $urandom}; wb_strb[0] = 8'hFF;
    awid = 4'hC; awaddr = 'h700; awlen = 0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    send_ar(4'hB, 'h600, 1, 3'd3);
    chk("coll1_awready_blocked", aw_rdy_at_ar, 0);
    read_data(4'hB, 'h600, 1, 1'b0, 0);
    send_aw(4'hC, 'h700, 0, 3'd3);
    write_data(4'hC, 'h700, 0, 1'b0, 0);
    arid = 4'hD; araddr = 'h700; arlen = 0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
    wb_data[0] = {$urandom, $urandom};
    send_aw(4'hE, 'h700, 0, 3'd3);
    chk("coll2_arready_blocked", ar_rdy_at_aw, 0);
    write_data(4'hE, 'h700, 0, 1'b0, 0);
    send_ar(4'hD, 'h700, 0, 3'd3);
    read_data(4'hD, 'h700, 0, 1'b0, 0);

    // Reset while beat 5 of an 8-beat read is outstanding.
    send_ar(4'h6, 'h800, 7, 3'd3);
    rready = 1'b1; nb = 0; cyc = 0;
    while (nb < 5 && cyc < 100) begin
      @(negedge clk);
      if (rvalid) begin
        chk("pre_rst_rdata", rdata, model_mem[word_of('h800) + nb]);
        nb++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (nb < 5) tmo("pre_rst_beats");
    @(negedge clk);
    rst = 1'b1; rready = 1'b0;
    #1;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_rlast", rlast, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_arready", arready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("postrst_arready", arready, 1);
    read_burst(4'h7, 'h800, 7, 3'd3, 0);

    gaps = 1'b1;
    for (int it = 0; it < 25; it++) begin
      len = $urandom_range(0, 15);
      addr = $urandom_range(0, DEPTH - 1) * 8 + $urandom_range(0, 7);
      sz = ($urandom_range(0, 5) == 0) ? 3'd2 : 3'd3;
      la = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 1) : len;
      for (int b = 0; b < 16; b++) begin
        wb_data[b] = {$urandom, $urandom};
        wb_strb[b] = 8'($urandom_range(0, 255));
      end
      write_burst(4'(it), addr, len, sz, la);
      read_burst(4'(it + 1), addr, $urandom_range(0, 15), ($urandom_range(0, 5) == 0) ? 3'd1 : 3'd3, 2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
